// File: rtl/out_fm_tile_rd_gen.sv
// Walks one out_fm tile in (tn, tr, tc) order, issues word reads and realigns the
// returned data into a push stream with exactly Tn*Tr*(Tc+TILE_ROW_OFFSET) words.
module out_fm_tile_rd_gen #(
    parameter int AW              = 16,
    parameter int CW              = 16,
    parameter int DW              = 32,
    parameter int N               = 32,
    parameter int R               = 64,
    parameter int C               = 32,
    parameter int M               = 1,
    parameter int K               = 1,
    parameter int S               = 1,
    parameter int Tn              = 16,
    parameter int Tr              = 64,
    parameter int Tc              = 16,
    parameter int TILE_ROW_OFFSET = 2,
    parameter int RD_LATENCY      = 2,
    parameter int OUT_FM_BASE     = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] tile_base_n,
    input  logic [CW-1:0] tile_base_row,
    input  logic [CW-1:0] tile_base_col,
    input  logic          fifo_almost_full,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          fifo_push_tmp,
    output logic [DW-1:0] data_to_fifo_tmp,
    output logic          busy,
    output logic          done
);
    // M, K, S only keep the parameter list uniform with sibling blocks.
    localparam int IW = CW + 1;
    localparam int PW = 2 * CW + 4 + 0 * (M + K + S);
    localparam logic [CW-1:0] TC_LAST = CW'(Tc + TILE_ROW_OFFSET - 1);
    localparam logic [CW-1:0] TR_LAST = CW'(Tr - 1);
    localparam logic [CW-1:0] TN_LAST = CW'(Tn - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         tn_q, tr_q, tc_q;
    logic [CW-1:0]         bn_q, br_q, bc_q;
    logic                  tok_vld_q, tok_zero_q;
    logic [RD_LATENCY-1:0] dl_vld_q, dl_zero_q;
    logic                  mem_rd_en_q, push_q, busy_q, done_q;
    logic [AW-1:0]         mem_rd_addr_q;
    logic [DW-1:0]         data_q;

    logic [IW-1:0] n_abs, r_abs, c_abs;
    logic          legal, issue_go, last_idx, dl_empty;
    logic [AW-1:0] rd_addr_d;

    always_comb begin
        n_abs     = {1'b0, bn_q} + {1'b0, tn_q};
        r_abs     = {1'b0, br_q} + {1'b0, tr_q};
        c_abs     = {1'b0, bc_q} + {1'b0, tc_q};
        legal     = (n_abs < IW'(N)) && (r_abs < IW'(R)) && (c_abs < IW'(C));
        // Wide intermediate keeps the row/column products exact before truncation.
        rd_addr_d = AW'(PW'(OUT_FM_BASE)
                        + (PW'(n_abs) * PW'(R) + PW'(r_abs)) * PW'(C)
                        + PW'(c_abs));
        issue_go  = (state_q == ISSUE) && !fifo_almost_full;
        last_idx  = (tc_q == TC_LAST) && (tr_q == TR_LAST) && (tn_q == TN_LAST);
        dl_empty  = !tok_vld_q && !(|dl_vld_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            tn_q          <= '0;
            tr_q          <= '0;
            tc_q          <= '0;
            bn_q          <= '0;
            br_q          <= '0;
            bc_q          <= '0;
            tok_vld_q     <= 1'b0;
            tok_zero_q    <= 1'b0;
            dl_vld_q      <= '0;
            dl_zero_q     <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            push_q        <= 1'b0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            mem_rd_en_q   <= issue_go && legal;
            mem_rd_addr_q <= (issue_go && legal) ? rd_addr_d : '0;
            tok_vld_q     <= issue_go;
            tok_zero_q    <= !legal;

            // Token line tracks the memory latency so is_zero meets its data word.
            dl_vld_q[0]  <= tok_vld_q;
            dl_zero_q[0] <= tok_zero_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                dl_vld_q[i]  <= dl_vld_q[i-1];
                dl_zero_q[i] <= dl_zero_q[i-1];
            end
            push_q <= dl_vld_q[RD_LATENCY-1];
            data_q <= dl_zero_q[RD_LATENCY-1] ? '0 : mem_rd_data;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        bn_q    <= tile_base_n;
                        br_q    <= tile_base_row;
                        bc_q    <= tile_base_col;
                        tn_q    <= '0;
                        tr_q    <= '0;
                        tc_q    <= '0;
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issue_go) begin
                        if (tc_q == TC_LAST) begin
                            tc_q <= '0;
                            if (tr_q == TR_LAST) begin
                                tr_q <= '0;
                                tn_q <= (tn_q == TN_LAST) ? '0 : tn_q + 1'b1;
                            end else begin
                                tr_q <= tr_q + 1'b1;
                            end
                        end else begin
                            tc_q <= tc_q + 1'b1;
                        end
                        if (last_idx) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (dl_empty) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_en        = mem_rd_en_q;
    assign mem_rd_addr      = mem_rd_addr_q;
    assign fifo_push_tmp    = push_q;
    assign data_to_fifo_tmp = data_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_out_fm_tile_rd_gen.sv
// Scoreboard bench for out_fm_tile_rd_gen on a reduced geometry with a latency-modelled memory.
module tb_out_fm_tile_rd_gen;
    localparam int AW = 16, CW = 16, DW = 32;
    localparam int N = 8, R = 8, C = 8;
    localparam int TN = 4, TR = 4, TC = 4, OFS = 2, LAT = 2, BASE = 256;
    localparam int WORDS = TN * TR * (TC + OFS);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] tbn = '0, tbr = '0, tbc = '0;
    logic          af = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          fifo_push_tmp;
    logic [DW-1:0] data_to_fifo_tmp;
    logic          busy, done;

    out_fm_tile_rd_gen #(
        .AW(AW), .CW(CW), .DW(DW), .N(N), .R(R), .C(C),
        .Tn(TN), .Tr(TR), .Tc(TC), .TILE_ROW_OFFSET(OFS),
        .RD_LATENCY(LAT), .OUT_FM_BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .tile_base_n(tbn), .tile_base_row(tbr), .tile_base_col(tbc),
        .fifo_almost_full(af),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .fifo_push_tmp(fifo_push_tmp), .data_to_fifo_tmp(data_to_fifo_tmp),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_rd_en ? mem_word(mem_rd_addr) : 32'hDEADBEEF;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rd_data = rd_pipe[LAT-1];

    int checks = 0, errors = 0;
    int cyc = 0, af_run = 0;
    int pushes = 0, reads = 0, done_cnt = 0, last_push_cyc = 0;
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_data [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        af_run <= af ? af_run + 1 : 0;
    end

    // af_run here counts the consecutive almost-full cycles up to the previous cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_rd_en) begin
                reads++;
                chk("rd_in_stall", af_run >= 1, 0);
                if (exp_addr.size() == 0) chk("rd_extra", 1, 0);
                else chk("rd_addr", mem_rd_addr, exp_addr.pop_front());
            end
            if (fifo_push_tmp) begin
                pushes++;
                last_push_cyc = cyc;
                chk("push_in_stall", af_run >= LAT + 2, 0);
                if (exp_data.size() == 0) chk("push_extra", 1, 0);
                else chk("push_data", data_to_fifo_tmp, exp_data.pop_front());
            end
            if (done) begin
                done_cnt++;
                chk("done_gap", cyc - last_push_cyc, 1);
                chk("done_busy", busy, 1);
                chk("done_q_empty", exp_data.size(), 0);
            end
        end
    end

    function automatic int build_expect(input int bn, input int br, input int bc);
        int nr = 0;
        for (int n = 0; n < TN; n++)
            for (int r = 0; r < TR; r++)
                for (int c = 0; c < TC + OFS; c++) begin
                    int a = BASE + ((bn + n) * R + br + r) * C + bc + c;
                    if ((bn + n < N) && (br + r < R) && (bc + c < C)) begin
                        exp_addr.push_back(AW'(a));
                        exp_data.push_back(mem_word(AW'(a)));
                        nr++;
                    end else begin
                        exp_data.push_back('0);
                    end
                end
        return nr;
    endfunction

    task automatic pulse_start(input int bn, input int br, input int bc);
        @(posedge clk); #1;
        tbn = CW'(bn); tbr = CW'(br); tbc = CW'(bc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_tile(input int bn, input int br, input int bc,
                            input bit af_mode, input int restart_at);
        int exp_reads;
        exp_reads = build_expect(bn, br, bc);
        pushes = 0; reads = 0; done_cnt = 0;
        pulse_start(bn, br, bc);
        chk("busy_start", busy, 1);
        for (int k = 0; k < 4000 && done_cnt == 0; k++) begin
            if (af_mode) af = ((k % 12) < 5);
            start = (restart_at > 0 && pushes == restart_at);
            @(posedge clk); #1;
        end
        af = 1'b0; start = 1'b0;
        chk("timeout", done_cnt > 0, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("done_cnt", done_cnt, 1);
        chk("push_cnt", pushes, WORDS);
        chk("read_cnt", reads, exp_reads);
        chk("busy_idle", busy, 0);
        chk("exp_left", exp_data.size() + exp_addr.size(), 0);
        exp_data.delete(); exp_addr.delete();
    endtask

    initial begin
        #12;
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_rd_addr, 0);
        chk("rst_push", fifo_push_tmp, 0);
        chk("rst_data", data_to_fifo_tmp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1 rst = 1'b0;

        run_tile(0, 0, 0, 1'b0, 0);
        run_tile(0, 0, 4, 1'b0, 0);
        run_tile(6, 0, 0, 1'b0, 0);
        run_tile(1, 6, 3, 1'b0, 0);
        run_tile(0, 0, 0, 1'b1, 0);
        run_tile(0, 0, 0, 1'b0, 50);

        // Asynchronous reset in the middle of a load, then a clean restart.
        void'(build_expect(2, 1, 1));
        pushes = 0;
        pulse_start(2, 1, 1);
        for (int k = 0; k < 500 && pushes < 20; k++) @(posedge clk);
        chk("mid_reached", pushes >= 20, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_rd_en", mem_rd_en, 0);
        chk("arst_addr", mem_rd_addr, 0);
        chk("arst_push", fifo_push_tmp, 0);
        chk("arst_data", data_to_fifo_tmp, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        exp_data.delete(); exp_addr.delete();
        @(posedge clk); #1 rst = 1'b0;
        run_tile(0, 0, 0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
